// File: rtl/ccir656_rx.sv
// ============================================================================
// Module  : ccir656_rx
// Brief   : BT.656 receiver: timing-reference decode, lock, active-video gate.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ccir656_rx #(
  parameter int ACTIVE_SAMPLES = 1440,
  parameter int LINE_W         = 10
) (
  input  logic              clk27M,
  input  logic              rst,
  input  logic [7:0]        din,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  output logic              sav,
  output logic              eav,
  output logic              field,
  output logic              vblank,
  output logic [LINE_W-1:0] line_cnt,
  output logic              locked,
  output logic              xy_err,
  output logic              line_err
);

  localparam logic [1:0]  c_SCAN = 2'd0;
  localparam logic [1:0]  c_FF1  = 2'd1;
  localparam logic [1:0]  c_Z1   = 2'd2;
  localparam logic [1:0]  c_Z2   = 2'd3;
  localparam logic [10:0] c_LAST = 11'(ACTIVE_SAMPLES - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              w_xy_strobe;
  logic              w_xy_valid;
  logic              w_f;
  logic              w_v;
  logic              w_h;
  logic              r_active;
  logic [10:0]       r_sample_cnt;
  logic [7:0]        r_pix_data;
  logic              r_pix_valid;
  logic              r_sav;
  logic              r_eav;
  logic              r_field;
  logic              r_vblank;
  logic [LINE_W-1:0] r_line_cnt;
  logic              r_locked;
  logic              r_xy_err;
  logic              r_line_err;

  always_ff @(posedge clk27M) begin
    if (rst) r_state <= c_SCAN;
    else     r_state <= w_next_state;
  end

  // 0xFF restarts the preamble from any non-XY state, including inside video.
  always_comb begin
    w_next_state = c_SCAN;
    case (r_state)
      c_SCAN:  w_next_state = (din == 8'hFF) ? c_FF1 : c_SCAN;
      c_FF1:   w_next_state = (din == 8'hFF) ? c_FF1 : ((din == 8'h00) ? c_Z1 : c_SCAN);
      c_Z1:    w_next_state = (din == 8'hFF) ? c_FF1 : ((din == 8'h00) ? c_Z2 : c_SCAN);
      default: w_next_state = c_SCAN;
    endcase
  end

  always_comb begin
    w_xy_strobe = (r_state == c_Z2);
  end

  assign w_f = din[6];
  assign w_v = din[5];
  assign w_h = din[4];
  assign w_xy_valid = din[7]
                    && (din[3] == (w_v ^ w_h))
                    && (din[2] == (w_f ^ w_h))
                    && (din[1] == (w_f ^ w_v))
                    && (din[0] == (w_f ^ w_v ^ w_h));

  always_ff @(posedge clk27M) begin
    if (rst) begin
      r_active     <= 1'b0;
      r_sample_cnt <= '0;
      r_pix_data   <= 8'h00;
      r_pix_valid  <= 1'b0;
      r_sav        <= 1'b0;
      r_eav        <= 1'b0;
      r_field      <= 1'b0;
      r_vblank     <= 1'b0;
      r_line_cnt   <= '0;
      r_locked     <= 1'b0;
      r_xy_err     <= 1'b0;
      r_line_err   <= 1'b0;
    end else begin
      r_sav       <= 1'b0;
      r_eav       <= 1'b0;
      r_xy_err    <= 1'b0;
      r_line_err  <= 1'b0;
      r_pix_valid <= 1'b0;

      if (r_active) begin
        if (din == 8'hFF) begin
          // A reference code inside video means the line was cut short.
          r_active     <= 1'b0;
          r_sample_cnt <= '0;
          r_line_err   <= 1'b1;
          r_locked     <= 1'b0;
        end else begin
          r_pix_data  <= din;
          r_pix_valid <= 1'b1;
          if (r_sample_cnt == c_LAST) begin
            r_active     <= 1'b0;
            r_sample_cnt <= '0;
          end else begin
            r_sample_cnt <= r_sample_cnt + 11'd1;
          end
        end
      end

      if (w_xy_strobe) begin
        if (w_xy_valid) begin
          r_field  <= w_f;
          r_vblank <= w_v;
          if (w_h) begin
            r_eav    <= 1'b1;
            r_locked <= 1'b1;
            if (w_f != r_field)
              r_line_cnt <= '0;
            else if (r_line_cnt != {LINE_W{1'b1}})
              r_line_cnt <= r_line_cnt + 1'b1;
          end else begin
            r_sav <= 1'b1;
            if (!w_v && r_locked)
              r_active <= 1'b1;
          end
        end else begin
          r_xy_err <= 1'b1;
          r_locked <= 1'b0;
        end
      end
    end
  end

  assign pix_data  = r_pix_data;
  assign pix_valid = r_pix_valid;
  assign sav       = r_sav;
  assign eav       = r_eav;
  assign field     = r_field;
  assign vblank    = r_vblank;
  assign line_cnt  = r_line_cnt;
  assign locked    = r_locked;
  assign xy_err    = r_xy_err;
  assign line_err  = r_line_err;

endmodule

`default_nettype wire

// File: doc/ccir656_rx.md
CCIR656_RX -- requirements
Module: ccir656_rx

Interface
REQ-001 The block SHALL use one clock (clk27M) and one reset (rst), where rst is synchronous and active-high.
REQ-002 ACTIVE_SAMPLES, default 1440, SHALL set the number of active-video bytes per line after an SAV.
REQ-003 LINE_W, default 10, SHALL set the width of line_cnt.
REQ-004 clk27M  input  1  byte clock, rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 din  input  8  BT.656 byte stream from the CCIR656 generator.
REQ-007 pix_data  output  8  registered active-video byte.
REQ-008 pix_valid  output  1  pix_data qualifier.
REQ-009 sav  output  1  one-cycle pulse on a valid SAV code.
REQ-010 eav  output  1  one-cycle pulse on a valid EAV code.
REQ-011 field  output  1  F bit from the last valid XY byte.
REQ-012 vblank  output  1  V bit from the last valid XY byte.
REQ-013 line_cnt  output  LINE_W  lines since the last field change.
REQ-014 locked  output  1  timing-reference lock.
REQ-015 xy_err  output  1  one-cycle pulse on a bad XY byte.
REQ-016 line_err  output  1  one-cycle pulse on a truncated active line.

Function
REQ-017 The preamble FSM SHALL have states SCAN, FF1, Z1, Z2.
- SCAN: 0xFF -> FF1.
- FF1: 0x00 -> Z1; 0xFF -> FF1; any other byte -> SCAN.
- Z1: 0x00 -> Z2; 0xFF -> FF1; any other byte -> SCAN.
- Z2: any byte is the XY byte -> SCAN.
REQ-018 The XY byte SHALL be valid iff all of the following hold:
- bit7=1;
- bit3=V^H;
- bit2=F^H;
- bit1=F^V;
- bit0=F^V^H;
- where F=bit6, V=bit5, H=bit4.
REQ-019 On a valid XY byte in cycle n, field and vblank SHALL update at cycle n+1, and sav (H=0) or eav (H=1) SHALL pulse at cycle n+1.
REQ-020 On an invalid XY byte in cycle n, xy_err SHALL pulse at n+1, field/vblank/line_cnt SHALL hold, locked SHALL clear at n+1, and no sav/eav SHALL pulse.
REQ-021 locked SHALL set at the cycle after the first valid EAV and SHALL clear on xy_err or line_err.
REQ-022 A valid SAV with V=0 while locked (locked as of cycle n) SHALL open the active window starting with the byte in cycle n+1.
REQ-023 Inside the active window, each byte in cycle k SHALL appear on pix_data with pix_valid=1 at cycle k+1 (latency 1).
REQ-024 The window SHALL close after exactly ACTIVE_SAMPLES bytes, tracked by an internal 11-bit sample counter that wraps to 0 on close.
REQ-025 If 0xFF arrives inside the active window, it SHALL NOT be output, the window SHALL close, line_err SHALL pulse the next cycle, and the FSM SHALL still enter FF1.
REQ-026 Outside the active window, pix_valid SHALL be 0 and pix_data SHALL hold its last value.
REQ-027 On a valid EAV, if F differs from the current field, line_cnt SHALL load 0; otherwise it SHALL increment, saturating at 2^LINE_W-1.
REQ-028 A valid SAV with V=1 SHALL NOT open a window, and pix_valid SHALL stay 0 for the whole vertical blanking interval.
REQ-029 A valid XY byte and a window close in the same cycle is impossible by REQ-025; no other simultaneous events need arbitration.

Reset
REQ-030 While rst=1 at a clock edge, all outputs SHALL be 0 (pix_data=0x00), the FSM SHALL be in SCAN, the window SHALL be closed, and the sample counter SHALL be 0.
REQ-031 When rst asserts mid-line or mid-preamble, in-flight state SHALL be discarded, and the byte in the first cycle after rst deasserts SHALL be parsed from SCAN.

Verification
REQ-032 Reset release, then FF 00 00 0xF1 -> eav=1 at next cycle, field=1, vblank=1, locked=1, xy_err=0.
REQ-033 Locked with F=0, then FF 00 00 0x80 followed by 1440 bytes of 0x10..0x9F pattern -> sav pulse, exactly 1440 pix_valid cycles, each pix_data equal to the input byte delayed 1 cycle, pix_valid=0 afterwards.
REQ-034 FF 00 00 0x81 (bad protection bits) -> xy_err pulse, locked=0, field unchanged, no sav/eav.
REQ-035 Active line carrying 0xFF at byte 500 -> exactly 499 pix_valid cycles, line_err pulse, locked=0, next valid EAV re-locks.
REQ-036 Two EAVs with F=0 then an EAV with F=1 -> line_cnt 1, 2, then 0.
REQ-037 rst asserted during Z1 of a preamble, then 0x00 0xF1 after release -> no eav, all outputs 0.
